// File: rtl/frodo_mul_pkg.sv
// Shared types and helpers for the FrodoKEM multiply engine.
package frodo_mul_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic MODE_OUTER = 1'b0;
  localparam logic MODE_VEC   = 1'b1;

  // Reduce a value modulo 2^q_bits; callers cast the result down to their bus width.
  function automatic logic [63:0] mask_q(input logic [63:0] v, input int q_bits);
    logic [63:0] m;
    m = (q_bits >= 64) ? '1 : ((64'd1 << q_bits) - 64'd1);
    return v & m;
  endfunction

  function automatic logic secret_neg(input logic sign, input logic is_pos);
    return sign ^ ~is_pos;
  endfunction

endpackage

// File: rtl/frodo_mul_lane.sv
// One sign-magnitude secret times one coefficient, built as a shift-add and reduced mod 2^Q_BITS.
module frodo_mul_lane
  import frodo_mul_pkg::*;
#(
  parameter int W      = 16,
  parameter int SW     = 4,
  parameter int Q_BITS = 16
) (
  input  logic [SW-1:0] s,
  input  logic [W-1:0]  a,
  input  logic          is_pos,
  output logic [W-1:0]  p
);

  logic [W-1:0] mag_prod;
  logic [W-1:0] signed_prod;

  always_comb begin
    mag_prod = '0;
    for (int k = 0; k < SW - 1; k++) begin
      if (s[k]) mag_prod = mag_prod + (a << k);
    end
    // Negating a zero magnitude still yields zero, so both signs of m=0 agree.
    signed_prod = secret_neg(s[SW-1], is_pos) ? (-mag_prod) : mag_prod;
    p = W'(mask_q(64'(signed_prod), Q_BITS));
  end

endmodule

// File: rtl/frodo_mul_engine.sv
// FrodoKEM matrix-multiply engine: runs one BEATS-long job in vector or outer-product mode.
// Build option FRODO_MUL_ZEROIZE_EN clears datapath state at job end/abort and masks idle outputs.
module frodo_mul_engine
  import frodo_mul_pkg::*;
#(
  parameter int A      = 4,
  parameter int S      = 8,
  parameter int W      = 16,
  parameter int Q_BITS = 16,
  parameter int SW     = 4,
  parameter int BEATS  = 160
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              start_ready,
  input  logic              mode_mul1,
  input  logic              is_pos,
  input  logic [W*S-1:0]    acc_vec,
  input  logic [SW*S-1:0]   s_col,
  input  logic              abort,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [W*A-1:0]    a,
  input  logic [SW*A*S-1:0] s_mat,
  input  logic [W*A*S-1:0]  acc_mat,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W*A*S-1:0]  out_mat,
  output logic              vec_valid,
  input  logic              vec_ready,
  output logic [W*S-1:0]    out_vec,
  output logic              busy,
  output logic              done
);

  localparam int CW = $clog2(BEATS + 1);
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

  state_t state, state_next;
  logic mode_q, is_pos_q;
  logic take, kill, last_beat, zero_clear;
  logic [CW-1:0] counter;
  logic [W-1:0] row_state [S];
  logic [W-1:0] row_sum [S];
  logic [W-1:0] acc_w;
  logic [W*A*S-1:0] prod, mat_next, out_mat_q;
  logic [W*S-1:0] out_vec_q;

  // Outer-product mode reuses the row state to hold the latched secret column.
  for (genvar j = 0; j < S; j++) begin : g_row
    for (genvar i = 0; i < A; i++) begin : g_col
      logic [SW-1:0] sec;
      assign sec = (mode_q == MODE_VEC) ? s_mat[SW*(j*A+i) +: SW] : row_state[j][SW-1:0];
      frodo_mul_lane #(.W(W), .SW(SW), .Q_BITS(Q_BITS)) u_lane (
        .s      (sec),
        .a      (a[W*i +: W]),
        .is_pos (is_pos_q),
        .p      (prod[W*(j*A+i) +: W])
      );
    end
  end

  always_comb begin
    acc_w    = '0;
    mat_next = '0;
    for (int j = 0; j < S; j++) begin
      acc_w = row_state[j];
      for (int i = 0; i < A; i++) begin
        acc_w = acc_w + prod[W*(j*A+i) +: W];
        mat_next[W*(j*A+i) +: W] =
          W'(mask_q(64'(acc_mat[W*(j*A+i) +: W] + prod[W*(j*A+i) +: W]), Q_BITS));
      end
      row_sum[j] = W'(mask_q(64'(acc_w), Q_BITS));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next  = state;
    start_ready = (state == ST_IDLE);
    busy        = (state != ST_IDLE);
    kill        = abort && (state != ST_IDLE);
    in_ready    = (state == ST_RUN) && ((mode_q == MODE_VEC) || !out_valid || out_ready);
    take        = in_valid && in_ready && !abort;
    last_beat   = (counter == LAST);
    done        = !abort && (((state == ST_DRAIN) && out_valid && out_ready) ||
                             ((state == ST_DONE) && vec_valid && vec_ready));
    case (state)
      ST_IDLE:  if (start) state_next = ST_RUN;
      ST_RUN:   if (take && last_beat) state_next = (mode_q == MODE_VEC) ? ST_DONE : ST_DRAIN;
      ST_DRAIN: if (out_valid && out_ready) state_next = ST_IDLE;
      ST_DONE:  if (vec_valid && vec_ready) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
    if (kill) state_next = ST_IDLE;
  end

`ifdef FRODO_MUL_ZEROIZE_EN
  assign zero_clear = done || kill;
  assign out_mat    = out_valid ? out_mat_q : '0;
  assign out_vec    = vec_valid ? out_vec_q : '0;
`else
  assign zero_clear = 1'b0;
  assign out_mat    = out_mat_q;
  assign out_vec    = out_vec_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q    <= MODE_OUTER;
      is_pos_q  <= 1'b0;
      counter   <= '0;
      out_valid <= 1'b0;
      vec_valid <= 1'b0;
      out_mat_q <= '0;
      out_vec_q <= '0;
      for (int j = 0; j < S; j++) row_state[j] <= '0;
    end else begin
      if (state == ST_IDLE && start) begin
        mode_q   <= mode_mul1;
        is_pos_q <= is_pos;
        counter  <= '0;
        for (int j = 0; j < S; j++)
          row_state[j] <= (mode_mul1 == MODE_VEC) ? acc_vec[W*j +: W] : W'(s_col[SW*j +: SW]);
      end
      if (take) begin
        counter <= last_beat ? '0 : counter + CW'(1);
        if (mode_q == MODE_VEC) begin
          row_state <= row_sum;
          if (last_beat) begin
            for (int j = 0; j < S; j++) out_vec_q[W*j +: W] <= row_sum[j];
            vec_valid <= 1'b1;
          end
        end else begin
          out_mat_q <= mat_next;
          out_valid <= 1'b1;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (vec_valid && vec_ready) vec_valid <= 1'b0;
      if (kill) begin
        counter   <= '0;
        out_valid <= 1'b0;
        vec_valid <= 1'b0;
      end
      if (zero_clear) begin
        out_mat_q <= '0;
        out_vec_q <= '0;
        for (int j = 0; j < S; j++) row_state[j] <= '0;
      end
    end
  end

endmodule
